// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: tag type, owner encoding, tag table entry
// and issue FSM state constants.
package mem_arb_pkg;

  localparam int TAG_W     = 4;
  localparam int NTAGS_DEF = 16;
  localparam int LSQ_ID_W  = 4;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic {
    OWN_LSQ = 1'b0,
    OWN_IF  = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e                owner;
    logic [LSQ_ID_W-1:0]   lsq_id;
  } tag_entry_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/mem_arb_tag_pool.sv
// Memory tag pool: free vector, lowest-free encoder, owner/lsq_id table.
// Allocation reads only the registered free vector, so a tag freed this cycle is never reissued this cycle.
module mem_arb_tag_pool
  import mem_arb_pkg::*;
#(
  parameter int NTAGS = NTAGS_DEF,
  parameter int TAG_W = mem_arb_pkg::TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  tag_entry_t       alloc_entry_i,
  output logic             any_free_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  output logic             free_hit_o,
  output tag_entry_t       free_entry_o
);

  logic [NTAGS-1:0] free_q, free_d;
  tag_entry_t       table_q [NTAGS];

  always_comb begin
    alloc_tag_o = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_tag_o = TAG_W'(i);
    end
  end

  assign any_free_o   = |free_q;
  assign free_hit_o   = ~free_q[free_tag_i];
  assign free_entry_o = table_q[free_tag_i];

  always_comb begin
    free_d = free_q;
    if (free_i && free_hit_o) free_d[free_tag_i] = 1'b1;
    if (alloc_i)              free_d[alloc_tag_o] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q <= '1;
      for (int i = 0; i < NTAGS; i++) table_q[i] <= '0;
    end else begin
      free_q <= free_d;
      if (alloc_i) table_q[alloc_tag_o] <= alloc_entry_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory request port between LSQ (port 0) and fetch (port 1), tags requests
// and routes responses back by tag. Optional perf counters under MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NTAGS        = NTAGS_DEF,
  parameter int TAG_W        = mem_arb_pkg::TAG_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lsq_req_i,
  input  logic             lsq_rw_i,
  input  logic [31:0]      lsq_addr_i,
  input  logic [31:0]      lsq_wdata_i,
  input  logic [3:0]       lsq_id_i,
  output logic             lsq_gnt_o,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  output logic             if_gnt_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             mem_rw_o,
  output logic [TAG_W-1:0] mem_id_o,
  output logic             mem_valid_o,
  input  logic             mem_stall_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic [TAG_W-1:0] mem_rid_i,
  input  logic             mem_ready_i,
  output logic             lsq_rsp_valid_o,
  output logic [31:0]      lsq_rsp_data_o,
  output logic [3:0]       lsq_rsp_id_o,
  output logic             if_rsp_valid_o,
  output logic [31:0]      if_rsp_data_o,
  output logic             tag_err_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]      perf_lsq_gnt_o,
  output logic [31:0]      perf_if_gnt_o,
  output logic [31:0]      perf_stall_cyc_o
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic [TAG_W-1:0] id_q, id_d;
  logic             lrv_q, lrv_d, irv_q, irv_d, err_q, err_d;
  logic [31:0]      ldata_q, ldata_d, idata_q, idata_d;
  logic [3:0]       lid_q, lid_d;

  logic             any_free, free_hit, can_gnt, if_pri, gnt, rsp_hit;
  logic [TAG_W-1:0] alloc_tag;
  tag_entry_t       alloc_entry, rsp_entry;

  mem_arb_tag_pool #(.NTAGS(NTAGS), .TAG_W(TAG_W)) u_pool (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .alloc_i       (gnt),
    .alloc_entry_i (alloc_entry),
    .any_free_o    (any_free),
    .alloc_tag_o   (alloc_tag),
    .free_i        (mem_ready_i),
    .free_tag_i    (mem_rid_i),
    .free_hit_o    (free_hit),
    .free_entry_o  (rsp_entry)
  );

  // Issue slot is available when idle or when the held request is accepted this cycle.
  assign can_gnt   = ((state_q == ST_IDLE) || !mem_stall_i) && any_free;
  assign if_pri    = if_req_i && (!lsq_req_i || (starve_q == STARVE_MAX));
  assign if_gnt_o  = can_gnt && if_pri;
  assign lsq_gnt_o = can_gnt && lsq_req_i && !if_pri;
  assign gnt       = lsq_gnt_o || if_gnt_o;

  assign alloc_entry.owner  = if_gnt_o ? OWN_IF : OWN_LSQ;
  assign alloc_entry.lsq_id = if_gnt_o ? '0 : lsq_id_i;

  assign rsp_hit = mem_ready_i && free_hit;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    id_d     = id_q;
    if (gnt) begin
      state_d = ST_SEND;
      addr_d  = if_gnt_o ? if_addr_i : lsq_addr_i;
      wdata_d = if_gnt_o ? 32'h0 : lsq_wdata_i;
      rw_d    = if_gnt_o ? 1'b0 : lsq_rw_i;
      id_d    = alloc_tag;
    end else if ((state_q == ST_SEND) && !mem_stall_i) begin
      state_d = ST_IDLE;
    end
    // Saturate so a stalled window cannot push the count past the forcing point.
    if (if_gnt_o)                                 starve_d = '0;
    else if (if_req_i && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    lrv_d   = rsp_hit && (rsp_entry.owner == OWN_LSQ);
    irv_d   = rsp_hit && (rsp_entry.owner == OWN_IF);
    ldata_d = lrv_d ? mem_rdata_i : ldata_q;
    lid_d   = lrv_d ? rsp_entry.lsq_id : lid_q;
    idata_d = irv_d ? mem_rdata_i : idata_q;
    err_d   = err_q || (mem_ready_i && !free_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      id_q     <= '0;
      lrv_q    <= 1'b0;
      irv_q    <= 1'b0;
      ldata_q  <= '0;
      lid_q    <= '0;
      idata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      id_q     <= id_d;
      lrv_q    <= lrv_d;
      irv_q    <= irv_d;
      ldata_q  <= ldata_d;
      lid_q    <= lid_d;
      idata_q  <= idata_d;
      err_q    <= err_d;
    end
  end

  assign mem_valid_o     = (state_q == ST_SEND);
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_rw_o        = rw_q;
  assign mem_id_o        = id_q;
  assign lsq_rsp_valid_o = lrv_q;
  assign lsq_rsp_data_o  = ldata_q;
  assign lsq_rsp_id_o    = lid_q;
  assign if_rsp_valid_o  = irv_q;
  assign if_rsp_data_o   = idata_q;
  assign tag_err_o       = err_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] plg_q, pig_q, pst_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      plg_q <= '0;
      pig_q <= '0;
      pst_q <= '0;
    end else begin
      if (lsq_gnt_o) plg_q <= plg_q + 32'd1;
      if (if_gnt_o)  pig_q <= pig_q + 32'd1;
      if ((state_q == ST_SEND) && mem_stall_i) pst_q <= pst_q + 32'd1;
    end
  end

  assign perf_lsq_gnt_o   = plg_q;
  assign perf_if_gnt_o    = pig_q;
  assign perf_stall_cyc_o = pst_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a tag-set reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsq_req, lsq_rw, if_req, mem_stall, mem_ready;
  logic [31:0] lsq_addr, lsq_wdata, if_addr, mem_rdata;
  logic [3:0]  lsq_id, mem_rid;
  logic        lsq_gnt, if_gnt, mem_rw, mem_valid, lsq_rsp_valid, if_rsp_valid, tag_err;
  logic [31:0] mem_addr, mem_wdata, lsq_rsp_data, if_rsp_data;
  logic [3:0]  mem_id, lsq_rsp_id;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_lsq_gnt, perf_if_gnt, perf_stall_cyc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsq_req_i(lsq_req), .lsq_rw_i(lsq_rw), .lsq_addr_i(lsq_addr), .lsq_wdata_i(lsq_wdata),
    .lsq_id_i(lsq_id), .lsq_gnt_o(lsq_gnt),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rw_o(mem_rw), .mem_id_o(mem_id),
    .mem_valid_o(mem_valid), .mem_stall_i(mem_stall), .mem_rdata_i(mem_rdata),
    .mem_rid_i(mem_rid), .mem_ready_i(mem_ready),
    .lsq_rsp_valid_o(lsq_rsp_valid), .lsq_rsp_data_o(lsq_rsp_data), .lsq_rsp_id_o(lsq_rsp_id),
    .if_rsp_valid_o(if_rsp_valid), .if_rsp_data_o(if_rsp_data), .tag_err_o(tag_err)
`ifdef MEM_ARB_PERF_EN
    , .perf_lsq_gnt_o(perf_lsq_gnt), .perf_if_gnt_o(perf_if_gnt), .perf_stall_cyc_o(perf_stall_cyc)
`endif
  );

  // Reference model: set of issued tags with owner/id, starvation count, pending issue slot.
  bit          m_iss [16];
  bit          m_own [16];
  logic [3:0]  m_lid [16];
  int          m_starve;
  bit          m_pend, m_rw, m_lrv, m_irv, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_id, m_rspid;
  bit          e_lg, e_ig, o_lg, o_ig;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin m_iss[i] = 0; m_own[i] = 0; m_lid[i] = 0; end
    m_starve = 0; m_pend = 0; m_rw = 0; m_lrv = 0; m_irv = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_id = 0; m_rspid = 0;
  endtask

  task automatic idle_inputs();
    lsq_req = 0; lsq_rw = 0; lsq_addr = 0; lsq_wdata = 0; lsq_id = 0;
    if_req = 0; if_addr = 0; mem_stall = 0; mem_ready = 0; mem_rdata = 0; mem_rid = 0;
  endtask

  // Advance one clock; record observed grants and step the model.
  task automatic tick();
    logic [3:0]  t;
    int          nf;
    bit          can, ifw, s_stall, s_lreq, s_ireq, s_rdy, s_rw;
    logic [3:0]  s_rid, s_lid;
    logic [31:0] s_rdata, s_laddr, s_wdata, s_iaddr;
    #2;
    nf = 0; t = 0;
    for (int i = 15; i >= 0; i--) if (!m_iss[i]) begin t = 4'(i); nf++; end
    s_stall = mem_stall; s_lreq = lsq_req; s_ireq = if_req; s_rdy = mem_ready;
    s_rid = mem_rid; s_rdata = mem_rdata; s_laddr = lsq_addr; s_wdata = lsq_wdata;
    s_iaddr = if_addr; s_rw = lsq_rw; s_lid = lsq_id;
    can  = (!m_pend || !s_stall) && (nf > 0);
    ifw  = s_ireq && (!s_lreq || m_starve == 8);
    e_lg = can && s_lreq && !ifw;
    e_ig = can && ifw;
    o_lg = lsq_gnt; o_ig = if_gnt;
    @(posedge clk);
    m_lrv = 0; m_irv = 0;
    if (s_rdy) begin
      if (m_iss[s_rid]) begin
        if (m_own[s_rid]) m_irv = 1;
        else begin m_lrv = 1; m_rspid = m_lid[s_rid]; end
        m_rdata = s_rdata;
        m_iss[s_rid] = 0;
      end else m_err = 1;
    end
    if (e_lg || e_ig) begin
      m_iss[t] = 1; m_own[t] = e_ig; m_lid[t] = e_ig ? 4'd0 : s_lid;
      m_pend = 1; m_id = t;
      m_addr = e_ig ? s_iaddr : s_laddr;
      m_wdata = e_ig ? 32'd0 : s_wdata;
      m_rw = e_ig ? 1'b0 : s_rw;
    end else if (!s_stall) m_pend = 0;
    if (e_ig) m_starve = 0;
    else if (s_ireq && m_starve < 8) m_starve++;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    #1;
    n_checks++; if ({mem_valid, lsq_gnt, if_gnt, lsq_rsp_valid, if_rsp_valid, tag_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=000000", {mem_valid, lsq_gnt, if_gnt, lsq_rsp_valid, if_rsp_valid, tag_err}); end
    n_checks++; if ({mem_addr, mem_wdata, mem_id, mem_rw} !== 69'b0) begin
      n_fail++; $display("FAIL reset_mem got addr=%h id=%0d want 0", mem_addr, mem_id); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_single_load();
    do_reset();
    lsq_req = 1; lsq_addr = 32'h40; lsq_id = 4'd5; lsq_rw = 0;
    tick();
    n_checks++; if (o_lg !== 1'b1) begin n_fail++; $display("FAIL single_gnt got=%b want=1", o_lg); end
    n_checks++; if ({mem_valid, mem_id, mem_rw, mem_addr} !== {1'b1, 4'd0, 1'b0, 32'h40}) begin
      n_fail++; $display("FAIL single_issue got v=%b id=%0d rw=%b addr=%h want 1/0/0/40", mem_valid, mem_id, mem_rw, mem_addr); end
    lsq_req = 0;
    tick();
    mem_ready = 1; mem_rid = 0; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 0;
    n_checks++; if ({lsq_rsp_valid, lsq_rsp_id, lsq_rsp_data, if_rsp_valid} !== {1'b1, 4'd5, 32'hDEADBEEF, 1'b0}) begin
      n_fail++; $display("FAIL single_rsp got v=%b id=%0d d=%h want 1/5/deadbeef", lsq_rsp_valid, lsq_rsp_id, lsq_rsp_data); end
    tick();
    n_checks++; if (lsq_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_pulse got=%b want=0", lsq_rsp_valid); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    lsq_req = 1; lsq_addr = 32'h100; lsq_wdata = 32'h1234; lsq_rw = 1; lsq_id = 2;
    tick();
    lsq_addr = 32'h200; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({o_lg, mem_valid, mem_addr, mem_wdata, mem_rw} !== {1'b0, 1'b1, 32'h100, 32'h1234, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold[%0d] got gnt=%b v=%b addr=%h want 0/1/100", i, o_lg, mem_valid, mem_addr); end
    end
    mem_stall = 0;
    tick();
    lsq_req = 0;
    n_checks++; if ({o_lg, mem_valid, mem_addr, mem_id} !== {1'b1, 1'b1, 32'h200, 4'd1}) begin
      n_fail++; $display("FAIL stall_release got gnt=%b addr=%h id=%0d want 1/200/1", o_lg, mem_addr, mem_id); end
  endtask

  task automatic test_starvation();
    do_reset();
    lsq_req = 1; if_req = 1; lsq_addr = 32'hA0; if_addr = 32'hF00;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if ({o_lg, o_ig} !== 2'b10) begin n_fail++; $display("FAIL starve_lsq[%0d] got=%b want=10", i, {o_lg, o_ig}); end
    end
    tick();
    n_checks++; if ({o_lg, o_ig, mem_addr, mem_rw, mem_wdata} !== {2'b01, 32'hF00, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL starve_if got gnt=%b addr=%h want 01/f00", {o_lg, o_ig}, mem_addr); end
    tick();
    n_checks++; if ({o_lg, o_ig} !== 2'b10) begin n_fail++; $display("FAIL starve_clear got=%b want=10", {o_lg, o_ig}); end
    lsq_req = 0; if_req = 0;
    tick();
    mem_ready = 1; mem_rid = 4'd8; mem_rdata = 32'h600D;
    tick();
    mem_ready = 0;
    n_checks++; if ({if_rsp_valid, lsq_rsp_valid, if_rsp_data} !== {2'b10, 32'h600D}) begin
      n_fail++; $display("FAIL if_rsp got v=%b/%b d=%h want 1/0/600d", if_rsp_valid, lsq_rsp_valid, if_rsp_data); end
  endtask

  task automatic test_exhaustion();
    do_reset();
    lsq_req = 1;
    for (int i = 0; i < 16; i++) begin
      lsq_addr = 32'(i); lsq_id = 4'(i);
      tick();
      n_checks++; if ({o_lg, mem_id} !== {1'b1, 4'(i)}) begin
        n_fail++; $display("FAIL exhaust_gnt[%0d] got gnt=%b id=%0d", i, o_lg, mem_id); end
    end
    tick();
    n_checks++; if (o_lg !== 1'b0) begin n_fail++; $display("FAIL exhaust_full got=%b want=0", o_lg); end
    mem_ready = 1; mem_rid = 4'd3; mem_rdata = 32'h33;
    tick();
    mem_ready = 0;
    n_checks++; if ({o_lg, lsq_rsp_valid, lsq_rsp_id} !== {2'b01, 4'd3}) begin
      n_fail++; $display("FAIL exhaust_free got gnt=%b rv=%b id=%0d want 0/1/3", o_lg, lsq_rsp_valid, lsq_rsp_id); end
    lsq_addr = 32'hBEEF;
    tick();
    n_checks++; if ({o_lg, mem_id, mem_addr} !== {1'b1, 4'd3, 32'hBEEF}) begin
      n_fail++; $display("FAIL exhaust_reuse got gnt=%b id=%0d want 1/3", o_lg, mem_id); end
    lsq_req = 0;
  endtask

  task automatic test_stray();
    do_reset();
    mem_ready = 1; mem_rid = 4'd7; mem_rdata = 32'h77;
    tick();
    mem_ready = 0;
    n_checks++; if ({tag_err, lsq_rsp_valid, if_rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL stray got err/rv=%b want 100", {tag_err, lsq_rsp_valid, if_rsp_valid}); end
    tick(); tick();
    n_checks++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL stray_sticky got=%b want=1", tag_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    lsq_req = 1; lsq_addr = 32'h55;
    for (int i = 0; i < 4; i++) tick();
    lsq_req = 0;
    #3 rst_n = 0;
    #1;
    n_checks++; if ({mem_valid, mem_id, mem_addr, lsq_gnt} !== 38'b0) begin
      n_fail++; $display("FAIL async_rst got v=%b id=%0d addr=%h want 0", mem_valid, mem_id, mem_addr); end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1;
    lsq_req = 1; lsq_addr = 32'h66;
    tick();
    lsq_req = 0;
    n_checks++; if ({o_lg, mem_id} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL async_rst_tag got gnt=%b id=%0d want 1/0", o_lg, mem_id); end
    mem_ready = 1; mem_rid = 4'd2;
    tick();
    mem_ready = 0;
    n_checks++; if ({tag_err, lsq_rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL late_rsp got err/rv=%b want 10", {tag_err, lsq_rsp_valid}); end
  endtask

  task automatic test_random();
    int cand [$];
    do_reset();
    for (int c = 0; c < 800; c++) begin
      lsq_req   = ($urandom_range(0, 9) < 6);
      if_req    = ($urandom_range(0, 9) < 5);
      lsq_rw    = $urandom_range(0, 1);
      lsq_addr  = $urandom;
      lsq_wdata = $urandom;
      lsq_id    = 4'($urandom_range(0, 15));
      if_addr   = $urandom;
      mem_stall = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      cand.delete();
      for (int i = 0; i < 16; i++) if (m_iss[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 19) != 0)
        mem_rid = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        mem_rid = 4'($urandom_range(0, 15));
      tick();
      n_checks++; if ({o_lg, o_ig} !== {e_lg, e_ig}) begin
        n_fail++; $display("FAIL rnd_gnt[%0d] got=%b want=%b", c, {o_lg, o_ig}, {e_lg, e_ig}); end
      n_checks++; if (mem_valid !== m_pend || (m_pend && {mem_id, mem_addr, mem_wdata, mem_rw} !== {m_id, m_addr, m_wdata, m_rw})) begin
        n_fail++; $display("FAIL rnd_issue[%0d] got v=%b id=%0d addr=%h want v=%b id=%0d addr=%h", c, mem_valid, mem_id, mem_addr, m_pend, m_id, m_addr); end
      n_checks++; if ({lsq_rsp_valid, if_rsp_valid, tag_err} !== {m_lrv, m_irv, m_err}) begin
        n_fail++; $display("FAIL rnd_rsp[%0d] got=%b want=%b", c, {lsq_rsp_valid, if_rsp_valid, tag_err}, {m_lrv, m_irv, m_err}); end
      n_checks++; if ((m_lrv && {lsq_rsp_data, lsq_rsp_id} !== {m_rdata, m_rspid}) || (m_irv && if_rsp_data !== m_rdata)) begin
        n_fail++; $display("FAIL rnd_rsp_data[%0d] got l=%h/%0d i=%h want %h/%0d", c, lsq_rsp_data, lsq_rsp_id, if_rsp_data, m_rdata, m_rspid); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_stall_hold();
    test_starvation();
    test_exhaustion();
    test_stray();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
